// File: rtl/uart_fifo_rx_mgr.sv
// UART RX FIFO manager: single-entry holding register between the UART receiver
// and the RX FIFO, with drop/error counters, sticky overflow flag and an idle-gap
// frame-end strobe.
module uart_fifo_rx_mgr #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TMR_W    = 16,
  parameter int unsigned IDLE_CYC = 1000
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Rx_Done_sig,
  input  logic [7:0]       Rx_Dat,
  input  logic             Rx_Err_sig,
  input  logic             Full_sig,
  output logic             WR_Req_sig,
  output logic [7:0]       FIFO_WR_Dat,
  input  logic             Ovf_Clr,
  output logic             Ovf_Flag,
  output logic [CNT_W-1:0] Drop_Cnt,
  output logic [CNT_W-1:0] Err_Cnt,
  output logic             Frame_Done
);

  typedef enum logic {StEmpty, StLoaded} state_e;

  // Incremented timer value that triggers the frame-end pulse on the next cycle.
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(IDLE_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       hold_dat_q, hold_dat_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             ovf_q, ovf_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             armed_q, armed_d;
  logic             done_q, done_d;

  logic             good_byte;
  logic             err_byte;
  logic             wr_en;
  logic             drop;
  logic [TMR_W-1:0] tmr_inc;

  // Input qualification and write/drop decisions for the current cycle.
  always_comb begin
    good_byte = Rx_Done_sig & ~Rx_Err_sig;
    err_byte  = Rx_Done_sig & Rx_Err_sig;
    // Write decoded from registered hold state, gated by the live full flag so a
    // stall is released in the very first non-full cycle.
    wr_en     = (state_q == StLoaded) & ~Full_sig;
    drop      = good_byte & (state_q == StLoaded) & ~wr_en;
    tmr_inc   = tmr_q + TMR_W'(1);
  end

  // State register: FSM, hold register, counters, flag and idle timer.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= StEmpty;
      hold_dat_q <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      tmr_q      <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_dat_q <= hold_dat_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ovf_q      <= ovf_d;
      tmr_q      <= tmr_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    hold_dat_d = hold_dat_q;
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    ovf_d      = ovf_q;
    tmr_d      = tmr_q;
    armed_d    = armed_q;
    done_d     = 1'b0;

    unique case (state_q)
      StEmpty: begin
        if (good_byte) state_d = StLoaded;
      end
      StLoaded: begin
        if (wr_en && !good_byte) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase

    if (good_byte && !drop) hold_dat_d = Rx_Dat;

    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (err_byte && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);

    // Set wins over clear.
    if (Ovf_Clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    // Any good byte, even a dropped one, restarts the idle gap.
    if (good_byte) begin
      tmr_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      tmr_d = tmr_inc;
      if (tmr_inc == TmrLast) begin
        done_d  = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  // Output decode.
  always_comb begin
    WR_Req_sig  = wr_en;
    FIFO_WR_Dat = hold_dat_q;
    Ovf_Flag    = ovf_q;
    Drop_Cnt    = drop_cnt_q;
    Err_Cnt     = err_cnt_q;
    Frame_Done  = done_q;
  end

endmodule

// File: tb/tb_uart_fifo_rx_mgr.sv
// Directed self-checking bench for uart_fifo_rx_mgr (IDLE_CYC reduced to 8).
module tb_uart_fifo_rx_mgr;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TMR_W    = 16;
  localparam int unsigned IDLE_CYC = 8;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             Rx_Done_sig;
  logic [7:0]       Rx_Dat;
  logic             Rx_Err_sig;
  logic             Full_sig;
  logic             WR_Req_sig;
  logic [7:0]       FIFO_WR_Dat;
  logic             Ovf_Clr;
  logic             Ovf_Flag;
  logic [CNT_W-1:0] Drop_Cnt;
  logic [CNT_W-1:0] Err_Cnt;
  logic             Frame_Done;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_fifo_rx_mgr #(
    .CNT_W    (CNT_W),
    .TMR_W    (TMR_W),
    .IDLE_CYC (IDLE_CYC)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Rx_Done_sig (Rx_Done_sig),
    .Rx_Dat      (Rx_Dat),
    .Rx_Err_sig  (Rx_Err_sig),
    .Full_sig    (Full_sig),
    .WR_Req_sig  (WR_Req_sig),
    .FIFO_WR_Dat (FIFO_WR_Dat),
    .Ovf_Clr     (Ovf_Clr),
    .Ovf_Flag    (Ovf_Flag),
    .Drop_Cnt    (Drop_Cnt),
    .Err_Cnt     (Err_Cnt),
    .Frame_Done  (Frame_Done)
  );

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic good(input logic [7:0] d);
    Rx_Done_sig = 1'b1;
    Rx_Err_sig  = 1'b0;
    Rx_Dat      = d;
  endtask

  task automatic quiet();
    Rx_Done_sig = 1'b0;
    Rx_Err_sig  = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; Rx_Done_sig = 1'b0; Rx_Dat = 8'h00; Rx_Err_sig = 1'b0;
    Full_sig = 1'b0; Ovf_Clr = 1'b0;
    #1;
    tick(); tick();
    #1;
    chk("rst_wr_req", WR_Req_sig, 0);
    chk("rst_dat",    FIFO_WR_Dat, 8'h00);
    chk("rst_ovf",    Ovf_Flag, 0);
    chk("rst_drop",   Drop_Cnt, 0);
    chk("rst_err",    Err_Cnt, 0);
    chk("rst_frame",  Frame_Done, 0);
    RSTn = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // 1: single byte, FIFO not full -> write in the following cycle only
    good(8'h5A); #1;
    chk("t1_no_req_same_cycle", WR_Req_sig, 0);
    tick(); quiet(); #1;
    chk("t1_req", WR_Req_sig, 1);
    chk("t1_dat", FIFO_WR_Dat, 8'h5A);
    tick(); #1;
    chk("t1_req_one_cycle", WR_Req_sig, 0);
    for (int i = 0; i < 10; i++) tick();

    // 2: byte during a full stall is written in the first non-full cycle
    Full_sig = 1'b1; tick();
    good(8'hA5); tick(); quiet();
    for (int i = 0; i < 14; i++) begin
      #1;
      chk("t2_stalled", WR_Req_sig, 0);
      tick();
    end
    Full_sig = 1'b0; #1;
    chk("t2_req", WR_Req_sig, 1);
    chk("t2_dat", FIFO_WR_Dat, 8'hA5);
    tick(); #1;
    chk("t2_req_one_cycle", WR_Req_sig, 0);

    // 3: second byte while held and full is dropped
    Full_sig = 1'b1;
    good(8'h11); tick();
    good(8'h22); tick(); quiet(); #1;
    chk("t3_drop", Drop_Cnt, 1);
    chk("t3_ovf", Ovf_Flag, 1);
    chk("t3_no_req_full", WR_Req_sig, 0);
    Full_sig = 1'b0; #1;
    chk("t3_req", WR_Req_sig, 1);
    chk("t3_dat_kept", FIFO_WR_Dat, 8'h11);
    tick(); #1;
    chk("t3_req_done", WR_Req_sig, 0);
    Ovf_Clr = 1'b1; tick(); Ovf_Clr = 1'b0; #1;
    chk("t3_ovf_clr", Ovf_Flag, 0);
    chk("t3_drop_kept", Drop_Cnt, 1);

    // 4: back-to-back bytes, no loss
    good(8'h01); tick();
    good(8'h02); #1;
    chk("t4_req1", WR_Req_sig, 1);
    chk("t4_dat1", FIFO_WR_Dat, 8'h01);
    tick(); good(8'h03); #1;
    chk("t4_req2", WR_Req_sig, 1);
    chk("t4_dat2", FIFO_WR_Dat, 8'h02);
    tick(); quiet(); #1;
    chk("t4_req3", WR_Req_sig, 1);
    chk("t4_dat3", FIFO_WR_Dat, 8'h03);
    tick(); #1;
    chk("t4_req_end", WR_Req_sig, 0);
    chk("t4_no_new_drop", Drop_Cnt, 1);
    chk("t4_no_ovf", Ovf_Flag, 0);

    // 5: error bytes are counted, never written, and the count saturates
    Rx_Done_sig = 1'b1; Rx_Err_sig = 1'b1; Rx_Dat = 8'hFF;
    tick(); quiet(); #1;
    chk("t5_no_req", WR_Req_sig, 0);
    chk("t5_err1", Err_Cnt, 1);
    Rx_Done_sig = 1'b1; Rx_Err_sig = 1'b1;
    for (int i = 0; i < 259; i++) tick();
    quiet(); #1;
    chk("t5_err_sat", Err_Cnt, 8'hFF);
    chk("t5_no_req_after", WR_Req_sig, 0);
    tick(); #1;
    chk("t5_no_req_late", WR_Req_sig, 0);
    for (int i = 0; i < 12; i++) tick();

    // 6a: byte at cycle 0 -> Frame_Done at cycle 8 only
    good(8'h77); tick(); quiet();
    for (int k = 1; k <= 12; k++) begin
      #1;
      chk($sformatf("t6a_frame_c%0d", k), Frame_Done, (k == 8) ? 1 : 0);
      tick();
    end

    // 6b: byte at cycle 0 and at cycle 7 -> pulse moves to cycle 15
    good(8'h78); tick(); quiet();
    for (int k = 1; k <= 18; k++) begin
      if (k == 7) good(8'h79);
      #1;
      chk($sformatf("t6b_frame_c%0d", k), Frame_Done, (k == 15) ? 1 : 0);
      tick();
      quiet();
    end

    // 7: reset with a byte held under stall discards it
    Full_sig = 1'b1;
    good(8'hC3); tick(); quiet();
    RSTn = 1'b0; tick(); RSTn = 1'b1;
    Full_sig = 1'b0; #1;
    chk("t7_no_req", WR_Req_sig, 0);
    chk("t7_err_clr", Err_Cnt, 0);
    chk("t7_drop_clr", Drop_Cnt, 0);
    tick(); #1;
    chk("t7_no_req_later", WR_Req_sig, 0);
    for (int k = 0; k < 10; k++) begin
      chk("t7_no_frame", Frame_Done, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
